uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_receiver.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
`timescale 1ns/1ps
// UART receiver: 2-flop synchronized rxd, mid-bit sampling FSM, show-ahead byte FIFO.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
  } state_t;
`endif

  // Receive path registers
  logic          sync1_reg;
  logic          sync2_reg;
  logic          rxd_prev_reg;
  state_t        state_reg,  state_next;
  logic [CW-1:0] baud_reg,   baud_next;
  logic [2:0]    bit_reg,    bit_next;
  logic [7:0]    shift_reg,  shift_next;
  logic          frame_err_reg, frame_err_next;
  logic          overrun_reg;
  logic          push;
  logic          rxd_s;
  logic          tick;

  // FIFO registers
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          full;
  logic          pop;
  logic          do_push;
  logic          drop;

  assign rxd_s = sync2_reg;
  assign tick  = (baud_reg == '0);

`ifdef UART_RX_PARITY_EN
  logic parity_err_reg, parity_err_next;
  logic par_bad_reg,    par_bad_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg     <= 1'b1;
      sync2_reg     <= 1'b1;
      rxd_prev_reg  <= 1'b1;
      state_reg     <= IDLE;
      baud_reg      <= '0;
      bit_reg       <= '0;
      shift_reg     <= '0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      sync1_reg     <= rxd;
      sync2_reg     <= sync1_reg;
      rxd_prev_reg  <= sync2_reg;
      state_reg     <= state_next;
      baud_reg      <= baud_next;
      bit_reg       <= bit_next;
      shift_reg     <= shift_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= drop;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err_reg <= 1'b0;
      par_bad_reg    <= 1'b0;
    end else begin
      parity_err_reg <= parity_err_next;
      par_bad_reg    <= par_bad_next;
    end
  end
`endif

  always_comb begin
    state_next     = state_reg;
    baud_next      = baud_reg;
    bit_next       = bit_reg;
    shift_next     = shift_reg;
    frame_err_next = 1'b0;
    push           = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_next = 1'b0;
    par_bad_next    = par_bad_reg;
`endif

    // Outside IDLE the counter free-runs; a zero count marks the sample cycle
    if (state_reg != IDLE) begin
      baud_next = tick ? FULL_LOAD : baud_reg - CW'(1);
    end

    case (state_reg)
      IDLE: begin
        if (rxd_prev_reg && !rxd_s) begin
          state_next = START;
          baud_next  = HALF_LOAD;
`ifdef UART_RX_PARITY_EN
          par_bad_next = 1'b0;
`endif
        end
      end
      START: begin
        if (tick) begin
          if (rxd_s) begin
            state_next = IDLE;
          end else begin
            state_next = DATA;
            bit_next   = 3'd0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_next = {rxd_s, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (rxd_s != ^shift_reg) begin
            parity_err_next = 1'b1;
            par_bad_next    = 1'b1;
          end
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (rxd_s) begin
`ifdef UART_RX_PARITY_EN
            push = !par_bad_reg;
`else
            push = 1'b1;
`endif
          end else begin
            frame_err_next = 1'b1;
          end
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign full    = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign pop     = valid && ready;
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= shift_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign valid     = (count_reg != '0);
  assign data      = valid ? mem[rd_ptr_reg] : 8'h00;
  assign busy      = (state_reg != IDLE);
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
// Bench for uart_receiver: frame-level queue model checked every cycle,
// directed scenarios plus randomized frames with random consumer backpressure.
module tb_uart_receiver;

  localparam int C = 4;
  localparam int D = 4;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // Start edge driven after cycle k reaches the stop-bit sample at cycle k+STOP_OFS:
  // 2 synchronizer flops + 1 edge-detect cycle, half a bit, then start+8 data(+parity) bits.
  localparam int STOP_OFS = 3 + C / 2 + (9 + PAR) * C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  uart_receiver #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .data(data), .valid(valid),
    .ready(ready), .busy(busy), .frame_err(frame_err),
    .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Behavioural model: byte queue plus scheduled frame events
  int         cyc = 0;
  logic [7:0] mq[$];
  logic [7:0] push_at[int];
  bit         ferr_at[int];
  bit         perr_at[int];
  bit         exp_ferr = 0, exp_ovr = 0, exp_perr = 0;
  bit         m_pop;
  int         busy_lo = 0, busy_hi = -1;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      mq.delete();
      exp_ferr = 0; exp_ovr = 0; exp_perr = 0;
      busy_hi = -1;
    end else begin
      m_pop = ready && (mq.size() != 0);
      if (m_pop) void'(mq.pop_front());
      exp_ovr = 0;
      if (push_at.exists(cyc)) begin
        if (mq.size() == D) exp_ovr = 1;
        else mq.push_back(push_at[cyc]);
        push_at.delete(cyc);
      end
      exp_ferr = ferr_at.exists(cyc);
      exp_perr = perr_at.exists(cyc);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("valid", 32'(valid), 32'(mq.size() != 0));
      check("data", 32'(data), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
      check("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
      check("frame_err", 32'(frame_err), 32'(exp_ferr));
      check("overrun", 32'(overrun), 32'(exp_ovr));
      check("parity_err", 32'(parity_err), 32'(exp_perr));
    end
  end

  // Observed traffic, used by the hand-computed expectations
  logic [7:0] got[$];
  int ferr_seen = 0, ovr_seen = 0, perr_seen = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (valid && ready) got.push_back(data);
      if (frame_err) ferr_seen++;
      if (overrun) ovr_seen++;
      if (parity_err) perr_seen++;
    end
  end

  bit rand_ready = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok, input int gap);
    int k;
    k = cyc;
    busy_lo = k + 3;
    busy_hi = k + STOP_OFS - 1;
    if (PAR != 0 && !par_ok) perr_at[k + STOP_OFS - C] = 1;
    if (!stop_ok) ferr_at[k + STOP_OFS] = 1;
    else if (PAR == 0 || par_ok) push_at[k + STOP_OFS] = b;
    rxd = 1'b0;
    repeat (C) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (C) tick();
    end
    if (PAR != 0) begin
      rxd = (^b) ^ !par_ok;
      repeat (C) tick();
    end
    rxd = stop_ok;
    repeat (C) tick();
    rxd = 1'b1;
    repeat (gap) tick();
  endtask

  logic [7:0] hello [5];
  logic [7:0] rb;
  int f0, o0, p0;

  initial begin
    hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C; hello[3] = 8'h4C; hello[4] = 8'h4F;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_data", 32'(data), 32'h0);
    check("rst_pulses", 32'({frame_err, overrun, parity_err}), 32'h0);
    tick();

    // Single byte, latency pinned to the stop-sample cycle
    ready = 1'b1;
    f0 = ferr_seen; o0 = ovr_seen; p0 = perr_seen;
    send_frame(8'h48, 1'b1, 1'b1, 0);
    @(negedge clk);
    check("h_before", 32'(valid), 32'h0);
    @(negedge clk);
    check("h_valid", 32'(valid), 32'h1);
    check("h_data", 32'(data), 32'h48);
    @(negedge clk);
    check("h_after", 32'(valid), 32'h0);
    tick();
    check("h_no_err", 32'(ferr_seen + ovr_seen + perr_seen - f0 - o0 - p0), 32'h0);
    repeat (4) tick();

    // Glitch rejection
    got.delete();
    f0 = ferr_seen; o0 = ovr_seen; p0 = perr_seen;
    busy_lo = cyc + 3;
    busy_hi = cyc + 4;
    rxd = 1'b0;
    tick();
    rxd = 1'b1;
    repeat (10) tick();
    check("glitch_none", 32'(got.size()), 32'h0);
    check("glitch_no_err", 32'(ferr_seen + ovr_seen + perr_seen - f0 - o0 - p0), 32'h0);

    // HELLO with consumer stalled: fifth byte overruns
    ready = 1'b0;
    got.delete();
    o0 = ovr_seen;
    for (int i = 0; i < 5; i++) send_frame(hello[i], 1'b1, 1'b1, 2);
    repeat (2) tick();
    check("hello_overrun", 32'(ovr_seen - o0), 32'h1);
    ready = 1'b1;
    repeat (8) tick();
    check("hello_count", 32'(got.size()), 32'h4);
    for (int i = 0; i < 4 && i < got.size(); i++) check("hello_byte", 32'(got[i]), 32'(hello[i]));

    // Bad stop bit, then a good frame
    got.delete();
    f0 = ferr_seen;
    send_frame(8'h55, 1'b0, 1'b1, 3);
    send_frame(8'hA5, 1'b1, 1'b1, 3);
    repeat (2) tick();
    check("ferr_count", 32'(ferr_seen - f0), 32'h1);
    check("ferr_next_count", 32'(got.size()), 32'h1);
    if (got.size() != 0) check("ferr_next_byte", 32'(got[0]), 32'hA5);

    // Reset while receiving data bit 3
    got.delete();
    rb = 8'hC3;
    busy_lo = cyc + 3;
    busy_hi = cyc + STOP_OFS - 1;
    rxd = 1'b0;
    repeat (C) tick();
    for (int i = 0; i < 3; i++) begin
      rxd = rb[i];
      repeat (C) tick();
    end
    rxd = rb[3];
    repeat (2) tick();
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_valid", 32'(valid), 32'h0);
    tick();
    send_frame(8'h3C, 1'b1, 1'b1, 3);
    check("post_rst_count", 32'(got.size()), 32'h1);
    if (got.size() != 0) check("post_rst_byte", 32'(got[0]), 32'h3C);

    if (PAR != 0) begin
      got.delete();
      p0 = perr_seen;
      send_frame(8'h48, 1'b1, 1'b1, 3);
      send_frame(8'h48, 1'b1, 1'b0, 3);
      check("par_good_count", 32'(got.size()), 32'h1);
      check("par_err_count", 32'(perr_seen - p0), 32'h1);
    end

    // Randomized frames with random backpressure
    rand_ready = 1;
    for (int n = 0; n < 40; n++) begin
      send_frame(8'($urandom), $urandom_range(0, 9) != 0,
                 (PAR == 0) || ($urandom_range(0, 4) != 0), $urandom_range(2, 6));
    end
    rand_ready = 0;
    ready = 1'b1;
    repeat (12) tick();
    @(negedge clk);
    check("final_empty", 32'(valid), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
